alu_muldiv_iter: RTL

//  Iterative RV32M multiply/divide unit. It runs next to the single-cycle ALU in the execute stage.
//  It executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over XLEN cycles, using valid/ready handshakes on both sides.
//  The control unit stalls the pipeline while busy=1. The result is muxed into the writeback path.

---
 rtl/alu_muldiv_iter_pkg.sv | 38 +++
 rtl/alu_muldiv_iter_step.sv | 37 +++
 rtl/alu_muldiv_iter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_iter_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 operation codes, FSM state encoding and operand-signedness helpers.
package alu_muldiv_iter_pkg;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  // Divide/remainder ops all have funct3[2] set.
  function automatic logic f3_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // rs1 is signed for MUL, MULH, MULHSU, DIV, REM.
  function automatic logic op1_signed(input logic [2:0] f3);
    return (f3 == INST_MUL) || (f3 == INST_MULH) || (f3 == INST_MULHSU) ||
           (f3 == INST_DIV) || (f3 == INST_REM);
  endfunction

  // rs2 is signed for MUL, MULH, DIV, REM (MULHSU treats it as unsigned).
  function automatic logic op2_signed(input logic [2:0] f3);
    return (f3 == INST_MUL) || (f3 == INST_MULH) ||
           (f3 == INST_DIV) || (f3 == INST_REM);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter_step.sv
// One iteration of the magnitude datapath. Multiply: shift-add, consuming
// one multiplier LSB from lo. Divide: restoring division, shifting one
// dividend bit from lo into the remainder and one quotient bit into lo.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN:0]   hi_i,    // product high half / remainder
  input  logic [XLEN-1:0] lo_i,    // multiplier+product low / dividend+quotient
  input  logic [XLEN-1:0] opnd_i,  // multiplicand / divisor
  output logic [XLEN:0]   hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN+1:0] div_shift;
  logic [XLEN:0]   div_sub;
  logic            div_ge;
  logic [XLEN:0]   mul_add;
  logic [XLEN:0]   mul_sum;

  // Compute both candidate updates and pick the one for the active op.
  always_comb begin
    div_shift = {hi_i, lo_i[XLEN-1]};
    div_ge    = (div_shift >= {2'b00, opnd_i});
    div_sub   = div_shift[XLEN:0] - {1'b0, opnd_i};
    mul_add   = lo_i[0] ? {1'b0, opnd_i} : '0;
    mul_sum   = {1'b0, hi_i[XLEN-1:0]} + mul_add;
    if (is_div_i) begin
      hi_o = div_ge ? div_sub : div_shift[XLEN:0];
      lo_o = {lo_i[XLEN-2:0], div_ge};
    end else begin
      hi_o = {1'b0, mul_sum[XLEN:1]};
      lo_o = {mul_sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv_iter.sv
// Iterative RV32M multiply/divide unit. Operands are latched as magnitudes,
// iterated XLEN times through muldiv_step, sign-corrected once and held
// until the consumer takes the result. Divide-by-zero and signed overflow
// skip the iteration entirely.
module alu_muldiv_iter
  import alu_muldiv_iter_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e state_q, state_d;

  logic [2:0]      f3_q, f3_d;
  logic            neg_a_q, neg_a_d;
  logic            neg_b_q, neg_b_d;
  logic            spec_q, spec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN:0]   hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            accept;
  logic            in_is_div, in_neg_a, in_neg_b, in_div0, in_ovf, in_special;
  logic [XLEN-1:0] in_abs_a, in_abs_b, in_spec_val;

  logic            calc_is_div;
  logic [XLEN:0]   step_hi;
  logic [XLEN-1:0] step_lo;

  logic [2*XLEN-1:0] prod_raw, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_val;

  // Request decode: signedness, magnitudes and the two special cases.
  always_comb begin
    in_is_div = f3_is_div(funct3);
    in_neg_a  = op1_signed(funct3) & operand1[XLEN-1];
    in_neg_b  = op2_signed(funct3) & operand2[XLEN-1];
    in_abs_a  = in_neg_a ? (~operand1 + 1'b1) : operand1;
    in_abs_b  = in_neg_b ? (~operand2 + 1'b1) : operand2;
    in_div0   = in_is_div & (operand2 == '0);
    in_ovf    = in_is_div & ~funct3[0] & (operand1 == MIN_INT) & (operand2 == '1);
    in_special = in_div0 | in_ovf;
    // funct3[1] distinguishes REM/REMU from DIV/DIVU.
    if (in_div0) begin
      in_spec_val = funct3[1] ? operand1 : '1;
    end else begin
      in_spec_val = funct3[1] ? '0 : MIN_INT;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush wins over everything else.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = MD_IDLE;
    end else begin
      unique case (state_q)
        MD_IDLE: if (in_valid) state_d = in_special ? MD_FIX : MD_CALC;
        MD_CALC: if (cnt_q == '0) state_d = MD_FIX;
        MD_FIX:  state_d = MD_DONE;
        MD_DONE: if (out_ready) state_d = MD_IDLE;
        default: state_d = MD_IDLE;
      endcase
    end
  end

  // Handshake/status outputs decoded from the registered state only.
  always_comb begin
    in_ready  = (state_q == MD_IDLE);
    busy      = (state_q != MD_IDLE);
    out_valid = (state_q == MD_DONE);
  end

  assign accept      = in_valid & in_ready & ~flush;
  assign calc_is_div = f3_is_div(f3_q);
  assign result      = result_q;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (calc_is_div),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opnd_i   (opnd_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  // Sign correction and result selection applied once in FIX.
  always_comb begin
    prod_raw = {hi_q[XLEN-1:0], lo_q};
    prod_fix = (neg_a_q ^ neg_b_q) ? (~prod_raw + 1'b1) : prod_raw;
    quot_fix = (neg_a_q ^ neg_b_q) ? (~lo_q + 1'b1) : lo_q;
    rem_fix  = neg_a_q ? (~hi_q[XLEN-1:0] + 1'b1) : hi_q[XLEN-1:0];
    if (spec_q) begin
      fix_val = lo_q;
    end else begin
      unique case (f3_q)
        INST_MUL:                            fix_val = prod_fix[XLEN-1:0];
        INST_MULH, INST_MULHSU, INST_MULHU:  fix_val = prod_fix[2*XLEN-1:XLEN];
        INST_DIV, INST_DIVU:                 fix_val = quot_fix;
        default:                             fix_val = rem_fix;
      endcase
    end
  end

  // Datapath next-state: latch on accept, iterate in CALC, capture in FIX.
  always_comb begin
    f3_d     = f3_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    spec_d   = spec_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    unique case (state_q)
      MD_IDLE: begin
        if (accept) begin
          f3_d    = funct3;
          neg_a_d = in_neg_a;
          neg_b_d = in_neg_b;
          spec_d  = in_special;
          cnt_d   = CNT_W'(XLEN - 1);
          hi_d    = '0;
          if (in_special) begin
            // Special result parked in lo so FIX can pass it straight through.
            opnd_d = '0;
            lo_d   = in_spec_val;
          end else if (in_is_div) begin
            opnd_d = in_abs_b;
            lo_d   = in_abs_a;
          end else begin
            opnd_d = in_abs_a;
            lo_d   = in_abs_b;
          end
        end
      end
      MD_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - 1'b1;
      end
      MD_FIX: begin
        if (!flush) result_d = fix_val;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f3_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      spec_q   <= 1'b0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      f3_q     <= f3_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      spec_q   <= spec_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end

endmodule
